// File: rtl/sha_uart_pkg.sv
// Shared definitions for the SHA-256 <-> UART message path.
// Holds the digest geometry, the unpacker state encoding and the byte-index split.
package sha_uart_pkg;

  localparam int DIGEST_WORDS = 8;
  localparam int DIGEST_BYTES = 32;
  localparam int BYTE_IDX_W   = 5;
  localparam int WORD_IDX_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_TX = 3'd3,
    ST_DONE    = 3'd4
  } unpack_state_t;

  typedef struct packed {
    logic [WORD_IDX_W-1:0] word;
    logic [1:0]            lane;
  } byte_sel_t;

  // Big-endian byte order: byte k comes from word k/4, lane 0 is the word's MSB.
  function automatic byte_sel_t byte_sel(input logic [BYTE_IDX_W-1:0] idx);
    byte_sel_t s;
    s.word = idx[BYTE_IDX_W-1:2];
    s.lane = idx[1:0];
    return s;
  endfunction

endpackage

// File: rtl/digest_byte_mux.sv
// Selects one big-endian byte out of the buffered digest words.
// Pure combinational; the caller registers the result.
module digest_byte_mux
  import sha_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = DIGEST_WORDS
) (
  input  logic [WORDS-1:0][DATA_WIDTH-1:0] i_buf,
  input  logic [BYTE_IDX_W-1:0]            i_byte_idx,
  output logic [7:0]                       o_byte
);

  byte_sel_t             w_sel;
  logic [DATA_WIDTH-1:0] w_word;

  always_comb begin
    w_sel  = byte_sel(i_byte_idx);
    w_word = i_buf[w_sel.word];
    o_byte = 8'h00;
    case (w_sel.lane)
      2'd0:    o_byte = w_word[DATA_WIDTH-1  -: 8];
      2'd1:    o_byte = w_word[DATA_WIDTH-9  -: 8];
      2'd2:    o_byte = w_word[DATA_WIDTH-17 -: 8];
      default: o_byte = w_word[DATA_WIDTH-25 -: 8];
    endcase
  end

endmodule

// File: rtl/digest_unpacker.sv
// Captures an 8-word SHA-256 digest from the core and streams it to the UART TX
// as 32 big-endian bytes, one byte per transmitter handshake.
//
//   state   | meaning
//   IDLE    | waiting for the first digest word (H0)
//   LOAD    | collecting H1..H7; aborts after LOAD_TIMEOUT idle cycles
//   ISSUE   | fetch byte[byte_cnt]; start pulse and byte appear next cycle
//   WAIT_TX | holding the byte until the transmitter reports completion
//   DONE    | one-cycle completion pulse, then back to IDLE
module digest_unpacker
  import sha_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int WORDS        = DIGEST_WORDS,
  parameter int LOAD_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] core_word_in,
  input  logic                  core_dv_in,
  output logic                  core_ready_out,
  output logic [7:0]            tx_byte_out,
  output logic                  tx_dv_out,
  input  logic                  tx_done_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  err_out
);

  localparam int                    TW         = $clog2(LOAD_TIMEOUT + 1);
  localparam int                    WIDX       = $clog2(WORDS);
  localparam logic [TW-1:0]         TIMEOUT_TC = TW'(LOAD_TIMEOUT);
  localparam logic [3:0]            LAST_WORD  = 4'(WORDS - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE  = BYTE_IDX_W'(DIGEST_BYTES - 1);

  unpack_state_t                   r_state;
  logic [WORDS-1:0][DATA_WIDTH-1:0] r_buf;
  logic [3:0]                      r_word_cnt;
  logic [BYTE_IDX_W-1:0]           r_byte_cnt;
  logic [TW-1:0]                   r_timer;
  logic [7:0]                      r_tx_byte;
  logic                            r_tx_dv;
  logic                            r_err;
  logic [7:0]                      w_byte;

  digest_byte_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS      (WORDS)
  ) u_byte_mux (
    .i_buf      (r_buf),
    .i_byte_idx (r_byte_cnt),
    .o_byte     (w_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_buf      <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_timer    <= '0;
      r_tx_byte  <= '0;
      r_tx_dv    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_tx_dv <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (core_dv_in) begin
            r_buf[0]   <= core_word_in;
            r_word_cnt <= 4'd1;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Timeout wins over a word arriving on the terminal-count cycle.
          if (r_timer == TIMEOUT_TC) begin
            r_err      <= 1'b1;
            r_buf      <= '0;
            r_word_cnt <= '0;
            r_timer    <= '0;
            r_state    <= ST_IDLE;
          end else if (core_dv_in) begin
            r_buf[r_word_cnt[WIDX-1:0]] <= core_word_in;
            r_word_cnt                  <= r_word_cnt + 4'd1;
            r_timer                     <= '0;
            if (r_word_cnt == LAST_WORD) begin
              r_byte_cnt <= '0;
              r_state    <= ST_ISSUE;
            end
          end else if (r_timer != TIMEOUT_TC) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_ISSUE: begin
          r_timer   <= '0;
          r_tx_byte <= w_byte;
          r_tx_dv   <= 1'b1;
          r_state   <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          r_timer <= '0;
          if (tx_done_in) begin
            if (r_byte_cnt == LAST_BYTE) begin
              r_state <= ST_DONE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
              r_state    <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          r_timer    <= '0;
          r_word_cnt <= '0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign core_ready_out = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign busy_out       = (r_state != ST_IDLE);
  assign done_out       = (r_state == ST_DONE);
  assign tx_dv_out      = r_tx_dv;
  assign tx_byte_out    = r_tx_byte;
  assign err_out        = r_err;

endmodule
